// File: rtl/mod_correct.sv
// Serial modular correction: conditionally subtracts (add mode) or adds (sub mode)
// the modulus to a raw 1028-bit adder result, one WORD_W limb per clock.
module mod_correct #(
    parameter int WORD_W = 128
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          subtract,
    input  logic [1027:0] in_x,
    input  logic [1026:0] in_m,
    output logic [1026:0] result,
    output logic          done
);
    localparam int NW = (1028 + WORD_W - 1) / WORD_W;
    localparam int TW = NW * WORD_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   x_reg;
    logic [TW-1:0]   m_reg;
    logic [TW-1:0]   acc_reg;
    logic [TW-1:0]   x_next;
    logic [TW-1:0]   m_next;
    logic [TW-1:0]   acc_next;
    logic            sub_reg;
    logic            carry_reg;
    logic            carry_next;
    logic [CW-1:0]   cnt;
    logic [WORD_W:0] limb;
    logic            last;
    logic            accept;
    logic            use_acc;
    logic [1026:0]   final_val;

    // Operands rotate right one limb per cycle, so after NW cycles they are back
    // in their original alignment and x is available intact for the final select.
    function automatic logic [TW-1:0] rotate(input logic [TW-1:0] v);
        return (v >> WORD_W) | (v << (TW - WORD_W));
    endfunction

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(NW - 1));

    always_comb begin
        if (sub_reg)
            limb = {1'b0, x_reg[WORD_W-1:0]} + {1'b0, m_reg[WORD_W-1:0]}
                 + {{WORD_W{1'b0}}, carry_reg};
        else
            limb = {1'b0, x_reg[WORD_W-1:0]} - {1'b0, m_reg[WORD_W-1:0]}
                 - {{WORD_W{1'b0}}, carry_reg};
        carry_next = limb[WORD_W];
        x_next     = rotate(x_reg);
        m_next     = rotate(m_reg);
        acc_next   = (acc_reg >> WORD_W) | (TW'(limb[WORD_W-1:0]) << (TW - WORD_W));
        // Add mode keeps x - M when no borrow came out; sub mode keeps x + M when x was negative.
        use_acc    = sub_reg ? x_next[1027] : ~carry_next;
        final_val  = use_acc ? acc_next[1026:0] : x_next[1026:0];
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (last) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            cnt       <= '0;
            carry_reg <= 1'b0;
        end else if (state == CALC) begin
            cnt       <= last ? '0 : cnt + CW'(1);
            carry_reg <= carry_next;
            if (last)
                result <= final_val;
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_reg   <= TW'(in_x);
            m_reg   <= TW'(in_m);
            sub_reg <= subtract;
        end else if (state == CALC) begin
            x_reg   <= x_next;
            m_reg   <= m_next;
            acc_reg <= acc_next;
        end
    end

endmodule

// File: doc/mod_correct.md
MOD_CORRECT -- requirements
Module: mod_correct

Interface
REQ-001 SHALL provide parameter WORD_W, default 128, meaning the datapath limb width in bits; legal range 32..1028.
REQ-002 SHALL derive NW = ceil(1028/WORD_W), the number of limbs, with operands zero-extended to NW*WORD_W bits internally.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 resetn  input  1  synchronous active-low reset.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 subtract  input  1  0 = in_x is a raw sum a+b; 1 = in_x is a raw difference a-b (1028-bit two's complement).
REQ-008 in_x  input  1028  raw 1028-bit result from the upstream multi-precision adder/subtractor.
REQ-009 in_m  input  1027  modulus M, with M > 0.
REQ-010 result  output  1027  reduced value in [0, M).
REQ-011 done  output  1  single-cycle completion strobe.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 IDLE + start=1 SHALL latch in_x, in_m and subtract, clear the limb counter and carry/borrow register, and go to CALC.
REQ-014 CALC SHALL process one WORD_W limb per cycle, LSB limb first, with the carry/borrow registered between limbs.
REQ-015 In add mode, CALC SHALL compute d = x - M serially over 1029 bits (x zero-extended).
REQ-016 In sub mode, CALC SHALL compute s = x + M modulo 2^1028.
REQ-017 CALC SHALL last exactly NW cycles, then go to DONE.
REQ-018 In DONE, add mode SHALL set result = d[1026:0] if the final borrow is 0 (x >= M), else x[1026:0].
REQ-019 In DONE, sub mode SHALL set result = s[1026:0] if x[1027] = 1 (negative difference), else x[1026:0].
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be fixed and data-independent: done high on the (NW+1)th rising edge after the edge that sampled start.
REQ-022 result SHALL be updated only on entry to the DONE cycle and SHALL hold stable until the next accepted start completes.
REQ-023 start in CALC or DONE SHALL be ignored, with no effect on the operation in flight.
REQ-024 start held high continuously SHALL begin a new operation in the IDLE cycle following DONE.
REQ-025 Input changes after the accepting edge SHALL NOT affect the operation in flight.
REQ-026 Precondition, not checked: add mode x < 2M; sub mode -M < x < M; out-of-range inputs give unspecified result but the same timing.
REQ-027 Boundary x == M in add mode SHALL yield result 0.
REQ-028 Boundary x == 0 in sub mode SHALL yield result 0.

Reset
REQ-029 While resetn=0 at a clock edge, the block SHALL enter IDLE with done=0, result=0, limb counter=0 and carry=0.
REQ-030 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse, and result SHALL be 0 after the edge.
REQ-031 start asserted in the first cycle with resetn=1 SHALL be accepted.

Verification
REQ-032 Add, M=0x5, x=0x3 -> result=0x3, done after NW+1 edges (10 for WORD_W=128).
REQ-033 Add, M=0x5, x=0x5 -> result=0x0; add, M=0x5, x=0x8 -> result=0x3; add, M=2^1026+1, x=2^1027 -> result=2^1026-1.
REQ-034 Sub, M=0x7, x=2^1028-2 (i.e. -2) -> result=0x5; sub, M=0x7, x=0x4 -> result=0x4; sub, x=0 -> result=0.
REQ-035 Start pulses on every cycle during CALC -> exactly one done pulse, with a result matching the first operands.
REQ-036 resetn low for one cycle at CALC cycle 3 -> no done pulse, result=0, and a subsequent operation completes correctly.
REQ-037 Random regression: 1000 operand pairs a,b < M, with M a random odd 1027-bit value, fed as a+b and as (a-b) mod 2^1028 -> result equals (a±b) mod M; run with WORD_W = 32, 128 and 1028.
